// File: rtl/dcache_evict_engine.sv
// Data-cache RAM-port engine: reads victim lines into an in-order write-back buffer and writes refill lines.
// Define DCACHE_EVICT_SKID_EN for a 2-entry write-back buffer; the default build holds a single line.
module dcache_evict_engine #(
    parameter int  DCACHE_NO_OF_SETS = 32,
    parameter int  NUM_COL           = 16,
    parameter int  COL_WIDTH         = 8,
    parameter int  ADDR_WIDTH        = $clog2(DCACHE_NO_OF_SETS),
    parameter int  TAG_WIDTH         = 20,
    localparam int DATA_WIDTH        = NUM_COL * COL_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          evict_req_i,
    output logic                          evict_ready_o,
    input  logic [ADDR_WIDTH-1:0]         evict_idx_i,
    input  logic [TAG_WIDTH-1:0]          evict_tag_i,

    input  logic                          fill_req_i,
    output logic                          fill_ready_o,
    input  logic [ADDR_WIDTH-1:0]         fill_idx_i,
    input  logic [DATA_WIDTH-1:0]         fill_data_i,

    output logic                          ram_req_o,
    output logic [NUM_COL-1:0]            ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0]         ram_addr_o,
    output logic [DATA_WIDTH-1:0]         ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]         ram_rdata_i,

    output logic                          wb_valid_o,
    input  logic                          wb_ready_i,
    output logic [TAG_WIDTH+ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0]         wb_data_o,

    output logic                          busy_o
);

`ifdef DCACHE_EVICT_SKID_EN
    localparam int WB_DEPTH = 2;
`else
    localparam int WB_DEPTH = 1;
`endif
    localparam int              WB_ADDR_W = TAG_WIDTH + ADDR_WIDTH;
    localparam logic [1:0]      WB_FULL   = 2'(WB_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_FILL
    } state_t;

    typedef struct packed {
        logic [WB_ADDR_W-1:0]  addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

    state_t                  state, state_next;
    logic                    evict_acc, fill_acc, capture, pop;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic [ADDR_WIDTH-1:0]   idx_q;

    logic                    ram_req_d;
    logic [NUM_COL-1:0]      ram_wr_en_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_wdata_d;

    // Storage is sized for the larger build; with one entry both pointers stay at 0.
    wb_entry_t               wb_buf [2];
    logic                    wb_head, wb_tail;
    logic [1:0]              wb_count;

    function automatic logic ptr_next(input logic p);
        return (WB_DEPTH == 1) ? 1'b0 : ~p;
    endfunction

    // A slot is owned from evict accept onward; in S_IDLE nothing is in flight, so occupancy suffices.
    assign evict_ready_o = (state == S_IDLE) && (wb_count != WB_FULL);
    assign fill_ready_o  = (state == S_IDLE) && !evict_req_i;
    assign evict_acc     = evict_req_i && evict_ready_o;
    assign fill_acc      = fill_req_i && fill_ready_o;
    assign capture       = (state == S_CAPTURE);
    assign pop           = wb_valid_o && wb_ready_i;

    // NOTE: every output of this block gets a default first so no latch is inferred on unlisted paths.
    always_comb begin
        state_next  = state;
        ram_req_d   = 1'b0;
        ram_wr_en_d = '0;
        ram_addr_d  = ram_addr_o;
        ram_wdata_d = ram_wdata_o;
        unique case (state)
            S_IDLE: begin
                if (evict_acc) begin
                    state_next = S_READ;
                    ram_req_d  = 1'b1;
                    ram_addr_d = evict_idx_i;
                end else if (fill_acc) begin
                    state_next  = S_FILL;
                    ram_req_d   = 1'b1;
                    ram_wr_en_d = '1;
                    ram_addr_d  = fill_idx_i;
                    ram_wdata_d = fill_data_i;
                end
            end
            S_READ:    state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_IDLE;
            S_FILL:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ram_req_o   <= 1'b0;
            ram_wr_en_o <= '0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            tag_q       <= '0;
            idx_q       <= '0;
        end else begin
            state       <= state_next;
            ram_req_o   <= ram_req_d;
            ram_wr_en_o <= ram_wr_en_d;
            ram_addr_o  <= ram_addr_d;
            ram_wdata_o <= ram_wdata_d;
            if (evict_acc) begin
                tag_q <= evict_tag_i;
                idx_q <= evict_idx_i;
            end
        end
    end

    // NOTE: the buffer is cleared on reset because its head drives wb_addr_o/wb_data_o directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wb_buf[i] <= '0;
            end
            wb_head  <= 1'b0;
            wb_tail  <= 1'b0;
            wb_count <= 2'd0;
        end else begin
            if (capture) begin
                wb_buf[wb_tail] <= {tag_q, idx_q, ram_rdata_i};
                wb_tail         <= ptr_next(wb_tail);
            end
            if (pop) begin
                wb_head <= ptr_next(wb_head);
            end
            if (capture && !pop) begin
                wb_count <= wb_count + 2'd1;
            end else if (pop && !capture) begin
                wb_count <= wb_count - 2'd1;
            end
        end
    end

    assign wb_valid_o = (wb_count != 2'd0);
    assign wb_addr_o  = wb_buf[wb_head].addr;
    assign wb_data_o  = wb_buf[wb_head].data;
    assign busy_o     = (state != S_IDLE) || (wb_count != 2'd0);

endmodule
